multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have parameter LAST_PC, default 13, giving the highest valid instruction index.
REQ-002 clk  in  1  sole clock; all state changes on posedge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 instruction  in  32  word from instruction memory; valid while state==DECODE and after.
REQ-005 rs_eq_rt  in  1  register-file comparator result (rs==rt), sampled in EXECUTE.
REQ-006 rs_lo  in  4  rs[3:0], used as jr target, sampled in EXECUTE.
REQ-007 mem_ready  in  1  data-memory read complete, sampled in MEMORY.
REQ-008 state  out  3  current phase; FETCH=0 drives instruction-memory load.
REQ-009 pc  out  4  instruction index.
REQ-010 reg_write, mem_read, mem_to_reg, alu_src_imm  out  1 each  datapath strobes.
REQ-011 reg_dst  out  2  write target: 0=rt, 1=rd, 2=r31.
REQ-012 alu_op  out  2  0=add, 1=slt, 2=sub.
REQ-013 halted, illegal  out  1 each  status flags.
REQ-014 retired  out  16  count of completed instructions.

Function
REQ-015 States SHALL be FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, HALT=5; codes 6/7 SHALL go to HALT with illegal=1.
REQ-016 FETCH SHALL last one cycle and always go to DECODE.
REQ-017 DECODE SHALL decode {opcode, funct}: addu(0/0x21), slt(0/0x2A), jr(0/0x08), addiu(0x09), beq(0x04), bne(0x05), lw(0x23), jal(0x03); any other encoding goes to HALT with illegal=1.
REQ-018 Sequences: addu/slt/addiu/jal take F-D-E-W (4 cycles); lw takes F-D-E-M-W (5 cycles, plus wait); beq/bne/jr take F-D-E (3 cycles).
REQ-019 MEMORY SHALL hold while mem_ready=0 and exit to WRITEBACK on the first cycle with mem_ready=1; mem_read=1 throughout MEMORY.
REQ-020 reg_write SHALL be 1 only in WRITEBACK; reg_dst=1 for addu/slt, 0 for addiu/lw, 2 for jal; mem_to_reg=1 only for lw.
REQ-021 alu_op: slt->1, beq/bne->2, else 0; alu_src_imm=1 for addiu/lw in EXECUTE/MEMORY/WRITEBACK.
REQ-022 pc SHALL update only on the last state of an instruction: default pc+1; taken beq (rs_eq_rt=1) or bne (rs_eq_rt=0) -> pc+1+imm[3:0]; jal -> instruction[3:0]; jr -> rs_lo; all mod 16.
REQ-023 jal SHALL have reg_dst=2 and write pc+1 (datapath-supplied link value).
REQ-024 If the next pc exceeds LAST_PC, the controller SHALL enter HALT instead of FETCH, pc holding the out-of-range value, halted=1, illegal=0.
REQ-025 retired SHALL increment by one on each instruction completion (including the one whose next pc triggers HALT), saturating at 0xFFFF.
REQ-026 HALT SHALL be absorbing; all strobes 0; exit only via reset.
REQ-027 All strobes SHALL be 0 outside the states listed above.

Reset
REQ-028 Reset SHALL asynchronously force state=FETCH, pc=0, retired=0, halted=0, illegal=0, all strobes 0.
REQ-029 Reset asserted mid-instruction SHALL abandon it without a register write or retired increment; first FETCH follows on the first posedge after deassertion.

Structure
REQ-030 State encodings, opcode/funct constants, alu_op and reg_dst codes SHALL live in a shared package used by the datapath.
REQ-031 A combinational sub-module mc_decoder SHALL map instruction to an instruction class and illegal flag; the FSM, pc and counter stay in multicycle_controller.

Verification
REQ-032 Reset, then addiu at pc0 -> states 0,1,2,4,0; reg_write=1 only in the 4th cycle, reg_dst=0; pc=1; retired=1.
REQ-033 lw with mem_ready low 3 cycles -> MEMORY held 4 cycles, total 8 cycles, mem_to_reg=1 in WRITEBACK.
REQ-034 beq imm=6 at pc=3, rs_eq_rt=1 -> pc=10 after 3 cycles; same with rs_eq_rt=0 -> pc=4; bne inverse.
REQ-035 jr at pc=11 with rs_lo=14 -> HALT, halted=1, pc=14, retired incremented.
REQ-036 Illegal opcode 0x3F -> HALT after DECODE, illegal=1, retired unchanged; reset asserted during EXECUTE -> immediate state=0, pc=0.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle controller and the datapath it steers:
// phase codes, instruction fields, ALU/register-destination selects and strobe bundles.
package multicycle_controller_pkg;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CLS_ADDU,
    CLS_SLT,
    CLS_JR,
    CLS_ADDIU,
    CLS_BEQ,
    CLS_BNE,
    CLS_LW,
    CLS_JAL,
    CLS_NONE
  } instr_class_t;

  localparam logic [5:0] OP_RTYPE   = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_LW      = 6'h23;

  localparam logic [5:0] FUNCT_JR   = 6'h08;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SLT = 2'd1;
  localparam logic [1:0] ALU_SUB = 2'd2;

  localparam logic [1:0] REG_DST_RT  = 2'd0;
  localparam logic [1:0] REG_DST_RD  = 2'd1;
  localparam logic [1:0] REG_DST_R31 = 2'd2;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_to_reg;
    logic       alu_src_imm;
    logic [1:0] reg_dst;
    logic [1:0] alu_op;
  } strobes_t;

  localparam strobes_t STROBES_IDLE = '0;

  // Datapath strobes to present while sitting in a given phase for a given class.
  function automatic strobes_t strobes_for(input state_t phase, input instr_class_t cls);
    strobes_t s;
    s = STROBES_IDLE;
    if (phase inside {S_EXECUTE, S_MEMORY, S_WRITEBACK}) begin
      if (cls == CLS_SLT)
        s.alu_op = ALU_SLT;
      else if (cls inside {CLS_BEQ, CLS_BNE})
        s.alu_op = ALU_SUB;
      else
        s.alu_op = ALU_ADD;
      s.alu_src_imm = (cls inside {CLS_ADDIU, CLS_LW});
    end
    s.mem_read = (phase == S_MEMORY);
    if (phase == S_WRITEBACK) begin
      s.reg_write  = 1'b1;
      s.mem_to_reg = (cls == CLS_LW);
      case (cls)
        CLS_ADDU, CLS_SLT: s.reg_dst = REG_DST_RD;
        CLS_JAL:           s.reg_dst = REG_DST_R31;
        default:           s.reg_dst = REG_DST_RT;
      endcase
    end
    return s;
  endfunction

  function automatic logic completes_in_execute(input instr_class_t cls);
    return (cls inside {CLS_BEQ, CLS_BNE, CLS_JR});
  endfunction

endpackage

// File: rtl/mc_decoder.sv
// Combinational instruction classifier: maps {opcode, funct} to an instruction class,
// flagging anything outside the supported subset as illegal.
module mc_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [31:0]  instruction,
  output instr_class_t instr_class,
  output logic         illegal
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_fields;

  assign opcode = instruction[31:26];
  assign funct  = instruction[5:0];

  // Register and immediate fields belong to the datapath, not to classification.
  assign unused_fields = ^instruction[25:6];

  always_comb begin
    instr_class = CLS_NONE;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FUNCT_ADDU: instr_class = CLS_ADDU;
          FUNCT_SLT:  instr_class = CLS_SLT;
          FUNCT_JR:   instr_class = CLS_JR;
          default:    instr_class = CLS_NONE;
        endcase
      end
      OP_ADDIU: instr_class = CLS_ADDIU;
      OP_BEQ:   instr_class = CLS_BEQ;
      OP_BNE:   instr_class = CLS_BNE;
      OP_LW:    instr_class = CLS_LW;
      OP_JAL:   instr_class = CLS_JAL;
      default:  instr_class = CLS_NONE;
    endcase
    illegal = (instr_class == CLS_NONE);
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle controller: steps each instruction through fetch/decode/execute/memory/writeback,
// owns the pc and the retired-instruction counter, and parks in HALT on illegal code or pc overrun.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int LAST_PC = 13
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        rs_eq_rt,
  input  logic [3:0]  rs_lo,
  input  logic        mem_ready,
  output logic [2:0]  state,
  output logic [3:0]  pc,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_to_reg,
  output logic        alu_src_imm,
  output logic [1:0]  reg_dst,
  output logic [1:0]  alu_op,
  output logic        halted,
  output logic        illegal,
  output logic [15:0] retired
);

  state_t       state_q;
  instr_class_t cls_q;
  instr_class_t dec_class;
  logic         dec_illegal;
  strobes_t     strobes_q;
  logic [3:0]   next_pc;
  logic         next_pc_out_of_range;
  logic         finishing;
  logic [15:0]  retired_next;

  mc_decoder u_decoder (
    .instruction (instruction),
    .instr_class (dec_class),
    .illegal     (dec_illegal)
  );

  // Successor pc for the instruction currently completing; wraps modulo 16.
  always_comb begin
    next_pc = pc + 4'd1;
    case (cls_q)
      CLS_BEQ: if (rs_eq_rt)  next_pc = pc + 4'd1 + instruction[3:0];
      CLS_BNE: if (!rs_eq_rt) next_pc = pc + 4'd1 + instruction[3:0];
      CLS_JAL: next_pc = instruction[3:0];
      CLS_JR:  next_pc = rs_lo;
      default: next_pc = pc + 4'd1;
    endcase
  end

  assign next_pc_out_of_range = (int'({28'd0, next_pc}) > LAST_PC);
  assign finishing = (state_q == S_WRITEBACK) ||
                     ((state_q == S_EXECUTE) && completes_in_execute(cls_q));
  assign retired_next = (retired == 16'hFFFF) ? retired : retired + 16'd1;

  // Strobes are registered alongside the state so they line up with the phase they belong to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc        <= 4'd0;
      retired   <= 16'd0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
      cls_q     <= CLS_NONE;
      strobes_q <= STROBES_IDLE;
    end else if (finishing) begin
      pc        <= next_pc;
      retired   <= retired_next;
      strobes_q <= STROBES_IDLE;
      if (next_pc_out_of_range) begin
        state_q <= S_HALT;
        halted  <= 1'b1;
      end else begin
        state_q <= S_FETCH;
      end
    end else begin
      case (state_q)
        S_FETCH: begin
          state_q   <= S_DECODE;
          strobes_q <= STROBES_IDLE;
        end
        S_DECODE: begin
          if (dec_illegal) begin
            state_q   <= S_HALT;
            illegal   <= 1'b1;
            strobes_q <= STROBES_IDLE;
          end else begin
            cls_q     <= dec_class;
            state_q   <= S_EXECUTE;
            strobes_q <= strobes_for(S_EXECUTE, dec_class);
          end
        end
        S_EXECUTE: begin
          if (cls_q == CLS_LW) begin
            state_q   <= S_MEMORY;
            strobes_q <= strobes_for(S_MEMORY, cls_q);
          end else begin
            state_q   <= S_WRITEBACK;
            strobes_q <= strobes_for(S_WRITEBACK, cls_q);
          end
        end
        S_MEMORY: begin
          if (mem_ready) begin
            state_q   <= S_WRITEBACK;
            strobes_q <= strobes_for(S_WRITEBACK, cls_q);
          end
        end
        S_HALT: begin
          strobes_q <= STROBES_IDLE;
        end
        default: begin
          state_q   <= S_HALT;
          illegal   <= 1'b1;
          strobes_q <= STROBES_IDLE;
        end
      endcase
    end
  end

  assign state       = state_q;
  assign reg_write   = strobes_q.reg_write;
  assign mem_read    = strobes_q.mem_read;
  assign mem_to_reg  = strobes_q.mem_to_reg;
  assign alu_src_imm = strobes_q.alu_src_imm;
  assign reg_dst     = strobes_q.reg_dst;
  assign alu_op      = strobes_q.alu_op;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: a table of instructions run back to back with a scoreboard,
// plus hand-written sequences for halt, illegal encodings and reset mid-instruction.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instruction = 32'd0;
  logic        rs_eq_rt = 1'b0;
  logic [3:0]  rs_lo = 4'd0;
  logic        mem_ready = 1'b0;
  logic [2:0]  state;
  logic [3:0]  pc;
  logic        reg_write;
  logic        mem_read;
  logic        mem_to_reg;
  logic        alu_src_imm;
  logic [1:0]  reg_dst;
  logic [1:0]  alu_op;
  logic        halted;
  logic        illegal;
  logic [15:0] retired;

  multicycle_controller #(.LAST_PC(13)) dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .rs_eq_rt    (rs_eq_rt),
    .rs_lo       (rs_lo),
    .mem_ready   (mem_ready),
    .state       (state),
    .pc          (pc),
    .reg_write   (reg_write),
    .mem_read    (mem_read),
    .mem_to_reg  (mem_to_reg),
    .alu_src_imm (alu_src_imm),
    .reg_dst     (reg_dst),
    .alu_op      (alu_op),
    .halted      (halted),
    .illegal     (illegal),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cycles;
    int pc;
    int retired;
    int state;
    int halted;
    int alu_op;
    int alu_src;
    int reg_dst;
    int mem_to_reg;
    int writes;
    int write_last;
    int mem_reads;
  } res_t;

  typedef struct {
    logic [31:0] instr;
    logic        eq;
    logic [3:0]  rs;
    int          mem_wait;
    res_t        exp;
  } vec_t;

  vec_t vecs[$];
  res_t scoreboard[$];
  int   passed = 0;
  int   total = 0;

  task automatic check(input string what, input int actual, input int expected);
    total++;
    if (actual == expected) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", what, actual, expected);
  endtask

  function automatic logic [31:0] r_type(input logic [5:0] funct);
    return {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, funct};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [15:0] imm);
    return {op, 5'd1, 5'd2, imm};
  endfunction

  function automatic vec_t make_vec(input logic [31:0] instr, input logic eq, input logic [3:0] rs,
                                    input int mem_wait, input int cycles, input int exp_pc,
                                    input int exp_retired, input int exp_state, input int exp_halted,
                                    input int exp_alu, input int exp_src, input int exp_dst,
                                    input int exp_m2r, input int exp_writes, input int exp_mreads);
    vec_t v;
    v.instr = instr;
    v.eq = eq;
    v.rs = rs;
    v.mem_wait = mem_wait;
    v.exp.cycles = cycles;
    v.exp.pc = exp_pc;
    v.exp.retired = exp_retired;
    v.exp.state = exp_state;
    v.exp.halted = exp_halted;
    v.exp.alu_op = exp_alu;
    v.exp.alu_src = exp_src;
    v.exp.reg_dst = exp_dst;
    v.exp.mem_to_reg = exp_m2r;
    v.exp.writes = exp_writes;
    v.exp.write_last = exp_writes;
    v.exp.mem_reads = exp_mreads;
    return v;
  endfunction

  // Entered at #1 after an edge with the DUT in FETCH; returns once it is back in FETCH or HALT.
  task automatic applyStimulus(input vec_t v, output res_t o);
    int mem_seen;
    bit done;
    o = '{default: 0};
    scoreboard.push_back(v.exp);
    instruction = v.instr;
    rs_eq_rt = v.eq;
    rs_lo = v.rs;
    mem_ready = 1'b0;
    mem_seen = 0;
    done = 1'b0;
    for (int c = 0; c < 24 && !done; c++) begin
      o.cycles++;
      if (state == 3'd2) begin
        o.alu_op = int'(alu_op);
        o.alu_src = int'(alu_src_imm);
      end
      if (state == 3'd3) begin
        mem_seen++;
        mem_ready = (mem_seen > v.mem_wait);
      end else begin
        mem_ready = 1'b0;
      end
      if (state == 3'd4) begin
        o.reg_dst = int'(reg_dst);
        o.mem_to_reg = int'(mem_to_reg);
      end
      o.mem_reads += int'(mem_read);
      o.writes += int'(reg_write);
      o.write_last = int'(reg_write);
      @(posedge clk); #1;
      done = (state == 3'd0) || (state == 3'd5);
    end
    mem_ready = 1'b0;
    check("instruction completes within cycle bound", int'(done), 1);
    o.pc = int'(pc);
    o.retired = int'(retired);
    o.state = int'(state);
    o.halted = int'(halted);
  endtask

  task automatic checkOutput(input int row, input res_t o);
    res_t e;
    check($sformatf("row%0d scoreboard depth", row), scoreboard.size(), 1);
    if (scoreboard.size() > 0) begin
      e = scoreboard.pop_front();
      check($sformatf("row%0d cycles", row), o.cycles, e.cycles);
      check($sformatf("row%0d pc", row), o.pc, e.pc);
      check($sformatf("row%0d retired", row), o.retired, e.retired);
      check($sformatf("row%0d end state", row), o.state, e.state);
      check($sformatf("row%0d halted", row), o.halted, e.halted);
      check($sformatf("row%0d alu_op", row), o.alu_op, e.alu_op);
      check($sformatf("row%0d alu_src_imm", row), o.alu_src, e.alu_src);
      check($sformatf("row%0d reg_dst", row), o.reg_dst, e.reg_dst);
      check($sformatf("row%0d mem_to_reg", row), o.mem_to_reg, e.mem_to_reg);
      check($sformatf("row%0d reg_write cycles", row), o.writes, e.writes);
      check($sformatf("row%0d reg_write in last cycle", row), o.write_last, e.write_last);
      check($sformatf("row%0d mem_read cycles", row), o.mem_reads, e.mem_reads);
    end
  endtask

  task automatic applyReset();
    reset = 1'b1;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  function automatic int strobe_bits();
    return int'({reg_write, mem_read, mem_to_reg, alu_src_imm, reg_dst, alu_op});
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    res_t o;
    logic [31:0] bad_codes [2];

    // instr, eq, rs_lo, mem_wait | cycles, pc, retired, state, halted, alu_op, imm, reg_dst, m2r, writes, mem_reads
    vecs.push_back(make_vec(i_type(6'h09, 16'd5), 0, 0, 0,  4,  1,  1, 0, 0, 0, 1, 0, 0, 1, 0));
    vecs.push_back(make_vec(r_type(6'h21),        0, 0, 0,  4,  2,  2, 0, 0, 0, 0, 1, 0, 1, 0));
    vecs.push_back(make_vec(r_type(6'h2A),        0, 0, 0,  4,  3,  3, 0, 0, 1, 0, 1, 0, 1, 0));
    vecs.push_back(make_vec(i_type(6'h04, 16'd6), 0, 0, 0,  3,  4,  4, 0, 0, 2, 0, 0, 0, 0, 0));
    vecs.push_back(make_vec(i_type(6'h05, 16'd2), 0, 0, 0,  3,  7,  5, 0, 0, 2, 0, 0, 0, 0, 0));
    vecs.push_back(make_vec(i_type(6'h05, 16'd5), 1, 0, 0,  3,  8,  6, 0, 0, 2, 0, 0, 0, 0, 0));
    vecs.push_back(make_vec(i_type(6'h23, 16'd4), 0, 0, 0,  5,  9,  7, 0, 0, 0, 1, 0, 1, 1, 1));
    vecs.push_back(make_vec(i_type(6'h23, 16'd8), 0, 0, 3,  8, 10,  8, 0, 0, 0, 1, 0, 1, 1, 4));
    vecs.push_back(make_vec({6'h03, 26'd3},       0, 0, 0,  4,  3,  9, 0, 0, 0, 0, 2, 0, 1, 0));
    vecs.push_back(make_vec(i_type(6'h04, 16'd6), 1, 0, 0,  3, 10, 10, 0, 0, 2, 0, 0, 0, 0, 0));
    vecs.push_back(make_vec(r_type(6'h08),        0, 11, 0, 3, 11, 11, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(make_vec(r_type(6'h08),        0, 14, 0, 3, 14, 12, 5, 1, 0, 0, 0, 0, 0, 0));

    applyReset();
    check("reset state", int'(state), 0);
    check("reset pc", int'(pc), 0);
    check("reset retired", int'(retired), 0);
    check("reset halted", int'(halted), 0);
    check("reset illegal", int'(illegal), 0);
    check("reset strobes", strobe_bits(), 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i], o);
      checkOutput(i, o);
    end

    $display("[TB] halt absorbing");
    instruction = i_type(6'h09, 16'd1);
    repeat (3) @(posedge clk);
    #1;
    check("halt holds state", int'(state), 5);
    check("halt holds pc", int'(pc), 14);
    check("halt holds retired", int'(retired), 12);
    check("halt keeps halted", int'(halted), 1);
    check("halt not illegal", int'(illegal), 0);
    check("halt strobes idle", strobe_bits(), 0);

    $display("[TB] illegal encodings");
    bad_codes[0] = 32'hFC00_0000;
    bad_codes[1] = r_type(6'h20);
    for (int k = 0; k < 2; k++) begin
      applyReset();
      instruction = bad_codes[k];
      @(posedge clk); #1;
      check($sformatf("illegal%0d decode state", k), int'(state), 1);
      @(posedge clk); #1;
      check($sformatf("illegal%0d halt state", k), int'(state), 5);
      check($sformatf("illegal%0d illegal flag", k), int'(illegal), 1);
      check($sformatf("illegal%0d halted flag", k), int'(halted), 0);
      check($sformatf("illegal%0d retired", k), int'(retired), 0);
      check($sformatf("illegal%0d pc", k), int'(pc), 0);
      @(posedge clk); #1;
      check($sformatf("illegal%0d stays halted", k), int'(state), 5);
    end

    $display("[TB] reset during execute");
    applyReset();
    applyStimulus(make_vec(i_type(6'h09, 16'd2), 0, 0, 0, 4, 1, 1, 0, 0, 0, 1, 0, 0, 1, 0), o);
    checkOutput(100, o);
    instruction = r_type(6'h21);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre-reset in execute", int'(state), 2);
    #2;
    reset = 1'b1;
    #1;
    check("async reset state", int'(state), 0);
    check("async reset pc", int'(pc), 0);
    check("async reset retired", int'(retired), 0);
    check("async reset strobes", strobe_bits(), 0);
    @(posedge clk); #1;
    check("reset held state", int'(state), 0);
    reset = 1'b0;
    applyStimulus(make_vec(i_type(6'h09, 16'd3), 0, 0, 0, 4, 1, 1, 0, 0, 0, 1, 0, 0, 1, 0), o);
    checkOutput(101, o);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
